// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator for a synchronous-write / asynchronous-read SRAM port.
//   Converts a core request (RV32 funct3, byte address, store data) into a word
//   address, byte-lane enables and lane-aligned write data. The request is held
//   on the memory port until the memory reports mem_valid_i. Loads return
//   sign/zero-extended data together with a one-cycle done_o pulse.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   : an access that sees no mem_valid_i for TIMEOUT cycles is
//                 aborted and completes with err_o=1.
//     undefined : ACCESS waits for mem_valid_i indefinitely.
//
// Parameters
//   MEM_ADDR_W  memory word-address width (mem_add_o = addr[MEM_ADDR_W+1:2])
//   TIMEOUT     ACCESS cycles before abort (only with LSU_TIMEOUT_EN, 1..31)
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, store_i      request strobe (sampled only when idle), 1=store
//   funct3_i            RV32 width/sign code
//   addr_i, wdata_i     byte address, LSB-aligned store data
//   busy_o              request in flight
//   done_o, err_o       completion pulse, error qualifier
//   rdata_o             load result, valid with done_o
//   mem_we_o, mem_re_o  memory write/read strobes
//   mem_ble_o           byte-lane enables
//   mem_d_o             lane-aligned write data
//   mem_add_o           word address
//   mem_d_i             read data (lanes already masked)
//   mem_valid_i         access complete (combinational from memory)
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  store_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    output logic [3:0]            mem_ble_o,
    output logic [31:0]           mem_d_o,
    output logic [MEM_ADDR_W-1:0] mem_add_o,
    input  logic [31:0]           mem_d_i,
    input  logic                  mem_valid_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  store_reg;
    logic [2:0]            funct3_reg;
    logic [1:0]            offs_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic [31:0]           rdata_reg;
    logic                  mem_we_reg;
    logic                  mem_re_reg;
    logic [3:0]            mem_ble_reg;
    logic [31:0]           mem_d_reg;
    logic [MEM_ADDR_W-1:0] mem_add_reg;

    // Request decode on the raw inputs; only used on the accept edge.
    logic        req_legal;
    logic [3:0]  req_ble;
    logic [31:0] req_wdata;

    always_comb begin
        req_legal = 1'b0;
        req_ble   = 4'b0000;
        case (funct3_i)
            3'b000: begin
                req_legal = 1'b1;
                req_ble   = 4'b0001 << addr_i[1:0];
            end
            3'b001: begin
                req_legal = ~addr_i[0];
                req_ble   = 4'b0011 << addr_i[1:0];
            end
            3'b010: begin
                req_legal = (addr_i[1:0] == 2'b00);
                req_ble   = 4'b1111;
            end
            3'b100: begin
                req_legal = ~store_i;           // unsigned variants exist for loads only
                req_ble   = 4'b0001 << addr_i[1:0];
            end
            3'b101: begin
                req_legal = ~store_i & ~addr_i[0];
                req_ble   = 4'b0011 << addr_i[1:0];
            end
            default: begin
                req_legal = 1'b0;
                req_ble   = 4'b0000;
            end
        endcase
        req_wdata = wdata_i << {addr_i[1:0], 3'b000};
    end

    // Load data: move the addressed lane down to bit 0, then extend.
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    always_comb begin
        load_shifted = mem_d_i >> {offs_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'b0, load_shifted[7:0]};
            3'b101:  load_data = {16'b0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [4:0] tmo_cnt_reg;
    logic       tmo_hit;
    assign tmo_hit = (tmo_cnt_reg == 5'(TIMEOUT - 1));
    logic unused_bits;
    assign unused_bits = ^addr_i[31:MEM_ADDR_W+2];
`else
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:MEM_ADDR_W+2], 32'(TIMEOUT)};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            store_reg   <= 1'b0;
            funct3_reg  <= 3'b000;
            offs_reg    <= 2'b00;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= 32'b0;
            mem_we_reg  <= 1'b0;
            mem_re_reg  <= 1'b0;
            mem_ble_reg <= 4'b0000;
            mem_d_reg   <= 32'b0;
            mem_add_reg <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_reg <= 5'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_i) begin
                        store_reg  <= store_i;
                        funct3_reg <= funct3_i;
                        offs_reg   <= addr_i[1:0];
                        rdata_reg  <= 32'b0;
                        if (req_legal) begin
                            state_reg   <= S_ACCESS;
                            mem_re_reg  <= ~store_i;
                            mem_we_reg  <= store_i;
                            mem_ble_reg <= req_ble;
                            mem_d_reg   <= store_i ? req_wdata : 32'b0;
                            mem_add_reg <= addr_i[MEM_ADDR_W+1:2];
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt_reg <= 5'd0;
`endif
                        end else begin
                            // Rejected: never touches the memory port.
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_valid_i) begin
                        state_reg   <= S_DONE;
                        done_reg    <= 1'b1;
                        err_reg     <= 1'b0;
                        if (!store_reg) begin
                            rdata_reg <= load_data;
                        end
                        mem_we_reg  <= 1'b0;
                        mem_re_reg  <= 1'b0;
                        mem_ble_reg <= 4'b0000;
                        mem_d_reg   <= 32'b0;
                        mem_add_reg <= '0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_reg   <= S_DONE;
                        done_reg    <= 1'b1;
                        err_reg     <= 1'b1;
                        rdata_reg   <= 32'b0;
                        mem_we_reg  <= 1'b0;
                        mem_re_reg  <= 1'b0;
                        mem_ble_reg <= 4'b0000;
                        mem_d_reg   <= 32'b0;
                        mem_add_reg <= '0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 5'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = (state_reg != S_IDLE);
    assign done_o    = done_reg;
    assign err_o     = err_reg;
    assign rdata_o   = rdata_reg;
    assign mem_we_o  = mem_we_reg;
    assign mem_re_o  = mem_re_reg;
    assign mem_ble_o = mem_ble_reg;
    assign mem_d_o   = mem_d_reg;
    assign mem_add_o = mem_add_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        store_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'b0;
    logic [31:0] wdata_i = 32'b0;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_we_o, mem_re_o;
    logic [3:0]  mem_ble_o;
    logic [31:0] mem_d_o;
    logic [9:0]  mem_add_o;
    logic [31:0] mem_d_i;
    logic        mem_valid_i;

    lsu_mem_master dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .store_i(store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_ble_o(mem_ble_o),
        .mem_d_o(mem_d_o), .mem_add_o(mem_add_o), .mem_d_i(mem_d_i),
        .mem_valid_i(mem_valid_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- memory model with WS wait states ----------------
    logic [31:0] mem [0:1023];
    int          ws = 0;
    int          wcnt = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] ble);
        lane_mask = {{8{ble[3]}}, {8{ble[2]}}, {8{ble[1]}}, {8{ble[0]}}};
    endfunction

    always_comb begin
        mem_valid_i = (mem_re_o | mem_we_o) && (wcnt >= ws);
        mem_d_i     = mem[mem_add_o] & lane_mask(mem_ble_o);
    end

    always @(posedge clk_i) begin
        if (!(mem_re_o | mem_we_o)) wcnt <= 0;
        else if (!mem_valid_i)      wcnt <= wcnt + 1;
        if (mem_we_o && mem_valid_i)
            mem[mem_add_o] <= (mem[mem_add_o] & ~lane_mask(mem_ble_o))
                            | (mem_d_o & lane_mask(mem_ble_o));
    end

    // ---------------- checking ----------------
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    // Completion monitor: every done_o pulse consumes one scoreboard entry.
    always @(negedge clk_i) begin
        if (done_o) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_err", {31'b0, err_o}, {31'b0, e.err});
                check("done_rdata", rdata_o, e.rdata);
            end
        end
    end

    // One transaction: drive, accept, follow the memory port, check latency.
    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        logic [3:0]  e_ble;
        logic [31:0] e_d;
        exp_t        e;
        int          n;
        case (f3[1:0])
            2'b00:   e_ble = 4'b0001 << a[1:0];
            2'b01:   e_ble = 4'b0011 << a[1:0];
            default: e_ble = 4'b1111;
        endcase
        e_d = st ? (wd << (8 * a[1:0])) : 32'b0;
        @(negedge clk_i);
        store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
        e.err = exp_err; e.rdata = exp_rd;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1 req_i = 1'b0;
        n = 0;
        while (n < 60) begin
            @(negedge clk_i);
            n++;
            if (exp_lat == 1) check({name, "_no_strobe"}, {30'b0, mem_re_o, mem_we_o}, 32'd0);
            if (done_o) break;
            if (exp_lat > 1) begin
                check({name, "_re"}, {31'b0, mem_re_o}, {31'b0, ~st});
                check({name, "_we"}, {31'b0, mem_we_o}, {31'b0, st});
                check({name, "_ble"}, {28'b0, mem_ble_o}, {28'b0, e_ble});
                check({name, "_add"}, {22'b0, mem_add_o}, {22'b0, a[11:2]});
                check({name, "_d"}, mem_d_o, e_d);
            end
        end
        check({name, "_latency"}, n, exp_lat);
        check({name, "_done_busy"}, {31'b0, busy_o}, 32'd1);
        check({name, "_done_strobe"}, {30'b0, mem_re_o, mem_we_o}, 32'd0);
        @(negedge clk_i);
        check({name, "_idle"}, {30'b0, busy_o, done_o}, 32'd0);
        $display("txn %s st=%0d f3=%03b addr=0x%08h err=%0d rdata=0x%08h lat=%0d",
                 name, st, f3, a, err_o, rdata_o, n);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk_i);
        check("rst_busy_done_err", {29'b0, busy_o, done_o, err_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_strobes", {26'b0, mem_re_o, mem_we_o, mem_ble_o}, 32'd0);
        check("rst_d_add", mem_d_o | {22'b0, mem_add_o}, 32'd0);
        rst_i = 1'b0;

        // WS = 0
        ws = 0;
        mem[4] = 32'hDEADBEEF;
        issue("lw",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        issue("sb",  1'b1, 3'b000, 32'h13, 32'h123456A5, 1'b0, 32'h0, 2);
        check("sb_mem", mem[4], 32'hA5ADBEEF);
        mem[4] = 32'h00800000;
        issue("lb",  1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFFFF80, 2);
        issue("lbu", 1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h00000080, 2);
        issue("lh",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'h00000080, 2);

        // Illegal requests
        issue("lh_mis",  1'b0, 3'b001, 32'h01, 32'h0, 1'b1, 32'h0, 1);
        issue("f3_011",  1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1);
        issue("sw_mis",  1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        issue("sbu_ill", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        check("illegal_mem_untouched", mem[8], 32'h0);

        // WS = 3
        ws = 3;
        mem[5] = 32'h13572468;
        issue("lw_ws3",  1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h13572468, 5);
        issue("sh_ws3",  1'b1, 3'b001, 32'h16, 32'hCAFEBEEF, 1'b0, 32'h0, 5);
        check("sh_mem", mem[5], 32'hBEEF2468);
        issue("lhu_ws3", 1'b0, 3'b101, 32'h16, 32'h0, 1'b0, 32'h0000BEEF, 5);
        issue("lh_ws3",  1'b0, 3'b001, 32'h16, 32'h0, 1'b0, 32'hFFFFBEEF, 5);

        // Reset in the middle of an access
        @(negedge clk_i);
        store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h30; wdata_i = 32'h55AA55AA; req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        check("mid_we", {31'b0, mem_we_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_ctrl", {25'b0, busy_o, done_o, err_o, mem_re_o, mem_we_o, 1'b0}, 32'd0);
        check("mid_rst_data", rdata_o | mem_d_o | {22'b0, mem_add_o} | {28'b0, mem_ble_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("mid_rst_no_done", {31'b0, done_o}, 32'd0);
        end
        check("mid_rst_no_write", mem[12], 32'h0);
        $display("txn rst_mid_access done");

`ifdef LSU_TIMEOUT_EN
        ws = 1000;
        issue("timeout", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h0, 16);
`endif

        repeat (2) @(negedge clk_i);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
